spram_arbiter: RTL and testbench

- Shares one single-clock `spram` instance between two requesters, A and B, for example a CPU-side port and a DMA/video-side port.
- Provides a per-port request/grant handshake with round-robin arbitration, one RAM access per cycle, and read-data return tagged to the issuing port.
- An optional post-reset clear sequencer fills the RAM with a constant before granting any access.

---
 rtl/spram_arb_pkg.sv | 15 +
 rtl/spram_rr_arb2.sv | 37 +++
 rtl/spram_arbiter.sv | 115 +++++++++++
 tb/tb_spram_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_arb_pkg.sv
// rtl/spram_arb_pkg.sv - shared state encoding, port ids and read latency for the spram arbiter
package spram_arb_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Cycles from grant to rvalid: one to register the address, one for the RAM q register.
  localparam int RD_LAT = 2;

endpackage

// File: rtl/spram_rr_arb2.sv
// rtl/spram_rr_arb2.sv - two-input round-robin arbiter with one-hot combinational grant
module spram_rr_arb2
  import spram_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  logic last;

  // Serve a lone requester; on a tie serve the port that was not granted most recently
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req[PORT_A] && (!req[PORT_B] || last == PORT_B)) begin
        gnt[PORT_A] = 1'b1;
      end else if (req[PORT_B]) begin
        gnt[PORT_B] = 1'b1;
      end
    end
  end

  // Remember the most recent winner; starting at B lets A take the first tie
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last <= PORT_B;
    end else if (gnt[PORT_A]) begin
      last <= PORT_A;
    end else if (gnt[PORT_B]) begin
      last <= PORT_B;
    end
  end

endmodule

// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - two-port round-robin front end for a single-clock spram with optional clear sweep
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int                    addr_width     = 8,
  parameter int                    data_width     = 8,
  parameter int                    numwords       = 1 << addr_width,
  parameter bit                    clear_on_reset = 1'b1,
  parameter logic [data_width-1:0] clear_value    = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  busy,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [addr_width-1:0] a_addr,
  input  logic [data_width-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [addr_width-1:0] b_addr,
  input  logic [data_width-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [data_width-1:0] rdata,
  output logic [addr_width-1:0] ram_rdaddress,
  output logic [addr_width-1:0] ram_wraddress,
  output logic [data_width-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [data_width-1:0] ram_q
);

  localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(numwords - 1);

  state_t                state;
  logic [addr_width-1:0] clr_addr;
  logic [1:0]            gnt;
  logic                  sel_b;
  logic                  gnt_we;
  logic [addr_width-1:0] gnt_addr;
  logic [data_width-1:0] gnt_wdata;
  logic [RD_LAT-1:0]     rd_v;
  logic [RD_LAT-1:0]     rd_id;

  // Arbitration is held off while the clear sweep owns the RAM and while reset is asserted
  spram_rr_arb2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     ({b_req, a_req}),
    .enable  ((state == ST_RUN) && reset_n),
    .gnt     (gnt)
  );

  assign a_gnt     = gnt[PORT_A];
  assign b_gnt     = gnt[PORT_B];
  assign sel_b     = gnt[PORT_B];
  assign gnt_we    = sel_b ? b_we    : a_we;
  assign gnt_addr  = sel_b ? b_addr  : a_addr;
  assign gnt_wdata = sel_b ? b_wdata : a_wdata;
  assign busy      = (state == ST_CLEAR);

  // Clear sweep / run FSM; also the issue stage that registers the RAM controls
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= clear_on_reset ? ST_CLEAR : ST_RUN;
      clr_addr      <= '0;
      ram_wren      <= 1'b0;
      ram_rdaddress <= '0;
      ram_wraddress <= '0;
      ram_data      <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          ram_wren      <= 1'b1;
          ram_data      <= clear_value;
          ram_rdaddress <= clr_addr;
          ram_wraddress <= clr_addr;
          // clr_addr parks on the last word so it never wraps
          if (clr_addr == LAST_ADDR) begin
            state <= ST_RUN;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: begin
          if (|gnt) begin
            ram_wren      <= gnt_we;
            ram_rdaddress <= gnt_addr;
            ram_wraddress <= gnt_addr;
            ram_data      <= gnt_wdata;
          end else begin
            ram_wren <= 1'b0;
          end
        end
      endcase
    end
  end

  // Track reads only, tagged with the issuing port, so writes never raise rvalid
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_v  <= '0;
      rd_id <= '0;
    end else begin
      rd_v  <= {rd_v[RD_LAT-2:0], (|gnt) && !gnt_we};
      rd_id <= {rd_id[RD_LAT-2:0], sel_b};
    end
  end

  assign a_rvalid = rd_v[RD_LAT-1] && (rd_id[RD_LAT-1] == PORT_A);
  assign b_rvalid = rd_v[RD_LAT-1] && (rd_id[RD_LAT-1] == PORT_B);
  assign rdata    = rd_v[RD_LAT-1] ? ram_q : '0;

endmodule

// File: tb/tb_spram_arbiter.sv
// tb/tb_spram_arbiter.sv - self-checking bench for spram_arbiter against a transaction-level model
module tb_spram_arbiter;

  localparam int        AW = 4;
  localparam int        DW = 8;
  localparam int        NW = 16;
  localparam logic [7:0] CV = 8'hA5;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          busy, a_gnt, a_rvalid, b_gnt, b_rvalid, ram_wren;
  logic [DW-1:0] rdata, ram_data, ram_q;
  logic [AW-1:0] ram_rdaddress, ram_wraddress;

  logic          c_reset_n = 1'b0;
  logic          c_a_req = 1'b0;
  logic [AW-1:0] c_a_addr = '0;
  logic          c_busy, c_a_gnt, c_a_rvalid, c_b_gnt, c_b_rvalid, c_ram_wren;
  logic [DW-1:0] c_rdata, c_ram_data;
  logic [DW-1:0] c_ram_q = 8'h5A;
  logic [AW-1:0] c_ram_rdaddress, c_ram_wraddress;

  spram_arbiter #(.addr_width(AW), .data_width(DW), .numwords(NW),
                  .clear_on_reset(1'b1), .clear_value(CV)) dut (
    .clock(clock), .reset_n(reset_n), .busy(busy),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .rdata(rdata), .ram_rdaddress(ram_rdaddress), .ram_wraddress(ram_wraddress),
    .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  spram_arbiter #(.addr_width(AW), .data_width(DW), .numwords(NW),
                  .clear_on_reset(1'b0), .clear_value(CV)) dut_nc (
    .clock(clock), .reset_n(c_reset_n), .busy(c_busy),
    .a_req(c_a_req), .a_we(1'b0), .a_addr(c_a_addr), .a_wdata(8'h00),
    .a_gnt(c_a_gnt), .a_rvalid(c_a_rvalid),
    .b_req(1'b0), .b_we(1'b0), .b_addr(4'h0), .b_wdata(8'h00),
    .b_gnt(c_b_gnt), .b_rvalid(c_b_rvalid),
    .rdata(c_rdata), .ram_rdaddress(c_ram_rdaddress), .ram_wraddress(c_ram_wraddress),
    .ram_data(c_ram_data), .ram_wren(c_ram_wren), .ram_q(c_ram_q)
  );

  // spram: registered q, write cycles leave q untouched
  logic [DW-1:0] mem [NW];
  always @(posedge clock) begin
    if (ram_wren) mem[ram_wraddress] <= ram_data;
    else          ram_q <= mem[ram_rdaddress];
  end

  typedef struct {
    int         cyc;
    bit         port;
    logic [7:0] data;
  } exp_t;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] mem_m [NW];
  exp_t       exp_q [$];
  bit         last_m;
  int         busy_left, cyc;
  bit         nx_chk, nx_wren, nx_data_chk;
  int         nx_addr;
  logic [7:0] nx_data;
  bit         got_a, got_b;
  int         busy_seen, cnt_a_gnt, cnt_b_gnt, cnt_a_rv, cnt_b_rv;
  logic [7:0] last_b_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    busy_seen = 0; cnt_a_gnt = 0; cnt_b_gnt = 0; cnt_a_rv = 0; cnt_b_rv = 0;
    last_b_rdata = 8'h00;
  endtask

  task automatic do_reset();
    a_req = 1'b0; b_req = 1'b0; reset_n = 1'b0;
    @(posedge clock); #1;
    cyc++;
    check("rst_busy", 32'(busy), 32'(1'b1));
    check("rst_a_gnt", 32'(a_gnt), 32'(1'b0));
    check("rst_b_gnt", 32'(b_gnt), 32'(1'b0));
    check("rst_a_rvalid", 32'(a_rvalid), 32'(1'b0));
    check("rst_b_rvalid", 32'(b_rvalid), 32'(1'b0));
    check("rst_ram_wren", 32'(ram_wren), 32'(1'b0));
    check("rst_ram_rdaddress", 32'(ram_rdaddress), 32'(0));
    check("rst_ram_wraddress", 32'(ram_wraddress), 32'(0));
    check("rst_ram_data", 32'(ram_data), 32'(0));
    check("rst_rdata", 32'(rdata), 32'(0));
    reset_n = 1'b1;
    exp_q.delete();
    busy_left = NW;
    last_m = 1'b1;
    for (int k = 0; k < NW; k++) mem_m[k] = CV;
    nx_chk = 1'b0;
  endtask

  // One cycle: compare DUT against the model at mid-cycle, then advance the model
  task automatic cycle_check();
    bit         ea, eb, busy_e, we;
    logic [3:0] addr;
    logic [7:0] wd;
    exp_t       e;
    @(negedge clock);
    busy_e = (busy_left > 0);
    check("busy", 32'(busy), 32'(busy_e));
    if (busy) busy_seen++;
    if (nx_chk) begin
      check("ram_wren", 32'(ram_wren), 32'(nx_wren));
      if (nx_wren) begin
        check("ram_wraddress", 32'(ram_wraddress), 32'(nx_addr));
        if (nx_data_chk) check("ram_data", 32'(ram_data), 32'(nx_data));
      end else if (nx_addr >= 0) begin
        check("ram_rdaddress", 32'(ram_rdaddress), 32'(nx_addr));
      end
    end
    ea = 1'b0; eb = 1'b0;
    if (!busy_e) begin
      if (a_req && b_req) begin
        if (last_m) ea = 1'b1; else eb = 1'b1;
      end else if (a_req) ea = 1'b1;
      else if (b_req) eb = 1'b1;
    end
    check("a_gnt", 32'(a_gnt), 32'(ea));
    check("b_gnt", 32'(b_gnt), 32'(eb));
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check("a_rvalid", 32'(a_rvalid), 32'(!e.port));
      check("b_rvalid", 32'(b_rvalid), 32'(e.port));
      check("rdata", 32'(rdata), 32'(e.data));
    end else begin
      check("a_rvalid_idle", 32'(a_rvalid), 32'(1'b0));
      check("b_rvalid_idle", 32'(b_rvalid), 32'(1'b0));
    end
    if (a_gnt) cnt_a_gnt++;
    if (b_gnt) cnt_b_gnt++;
    if (a_rvalid) cnt_a_rv++;
    if (b_rvalid) begin cnt_b_rv++; last_b_rdata = rdata; end
    nx_chk = 1'b1; nx_data_chk = 1'b0; nx_addr = -1;
    if (busy_e) begin
      nx_wren = 1'b1; nx_addr = NW - busy_left; nx_data = CV; nx_data_chk = 1'b1;
      busy_left--;
    end else if (ea || eb) begin
      we = ea ? a_we : b_we;
      addr = ea ? a_addr : b_addr;
      wd = ea ? a_wdata : b_wdata;
      nx_wren = we; nx_addr = int'(addr); nx_data = wd; nx_data_chk = we;
      if (we) mem_m[addr] = wd;
      else exp_q.push_back('{cyc + 2, eb, mem_m[addr]});
      last_m = eb;
    end else begin
      nx_wren = 1'b0;
    end
    got_a = ea; got_b = eb;
    @(posedge clock); #1;
    cyc++;
  endtask

  initial begin
    int gnt_at;
    bit pa, pb;
    cyc = 0;
    clear_counts();

    // reset values, then the clear sweep with A holding a read request
    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd3;
    gnt_at = -1;
    for (int i = 0; i < 40; i++) begin
      cycle_check();
      if (got_a) begin gnt_at = i; a_req = 1'b0; break; end
    end
    repeat (3) cycle_check();
    check("clear_busy_cycles", 32'(busy_seen), 32'(NW));
    check("clear_first_gnt", 32'(gnt_at), 32'(NW));
    check("clear_a_rvalids", 32'(cnt_a_rv), 32'(1));

    // seed addr 1 and 2 with distinct data
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd1; a_wdata = 8'h11;
    cycle_check();
    a_req = 1'b0; b_req = 1'b1; b_we = 1'b1; b_addr = 4'd2; b_wdata = 8'h22;
    cycle_check();
    b_req = 1'b0;
    cycle_check();

    // continuous tie: grants and returns must alternate
    clear_counts();
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd2;
    repeat (8) cycle_check();
    a_req = 1'b0; b_req = 1'b0;
    repeat (3) cycle_check();
    check("tie_a_gnts", 32'(cnt_a_gnt), 32'(4));
    check("tie_b_gnts", 32'(cnt_b_gnt), 32'(4));
    check("tie_a_rvalids", 32'(cnt_a_rv), 32'(4));
    check("tie_b_rvalids", 32'(cnt_b_rv), 32'(4));

    // write then read of the same address on consecutive grants
    clear_counts();
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd7; a_wdata = 8'h3C;
    cycle_check();
    a_req = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = 4'd7;
    cycle_check();
    b_req = 1'b0;
    repeat (3) cycle_check();
    check("hazard_rdata", 32'(last_b_rdata), 32'(8'h3C));
    check("hazard_b_rvalids", 32'(cnt_b_rv), 32'(1));
    check("hazard_a_rvalids", 32'(cnt_a_rv), 32'(0));

    // single requester back-to-back
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      b_req = 1'b1; b_we = 1'b0; b_addr = 4'(i);
      cycle_check();
    end
    b_req = 1'b0;
    repeat (3) cycle_check();
    check("b2b_b_gnts", 32'(cnt_b_gnt), 32'(4));
    check("b2b_b_rvalids", 32'(cnt_b_rv), 32'(4));
    check("b2b_a_rvalids", 32'(cnt_a_rv), 32'(0));

    // random traffic from both ports, requests held until granted
    pa = 1'b0; pb = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!pa && $urandom_range(0, 2) != 0) begin
        pa = 1'b1; a_we = 1'($urandom); a_addr = 4'($urandom); a_wdata = 8'($urandom);
      end
      if (!pb && $urandom_range(0, 2) != 0) begin
        pb = 1'b1; b_we = 1'($urandom); b_addr = 4'($urandom); b_wdata = 8'($urandom);
      end
      a_req = pa; b_req = pb;
      cycle_check();
      if (got_a) pa = 1'b0;
      if (got_b) pb = 1'b0;
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (3) cycle_check();

    // reset while a read is in flight: no rvalid, sweep restarts from 0
    clear_counts();
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd9;
    cycle_check();
    do_reset();
    repeat (NW + 2) cycle_check();
    check("midrst_a_rvalids", 32'(cnt_a_rv), 32'(0));
    check("midrst_busy_cycles", 32'(busy_seen), 32'(NW));

    // instance without the clear sweep: grant in the first cycle after release
    c_a_req = 1'b1; c_a_addr = 4'd5;
    @(negedge clock);
    check("nc_rst_a_gnt", 32'(c_a_gnt), 32'(1'b0));
    check("nc_rst_busy", 32'(c_busy), 32'(1'b0));
    check("nc_rst_ram_data", 32'(c_ram_data), 32'(0));
    check("nc_rst_ram_wraddress", 32'(c_ram_wraddress), 32'(0));
    @(posedge clock); #1;
    c_reset_n = 1'b1;
    @(negedge clock);
    check("nc_busy", 32'(c_busy), 32'(1'b0));
    check("nc_a_gnt", 32'(c_a_gnt), 32'(1'b1));
    check("nc_b_gnt", 32'(c_b_gnt), 32'(1'b0));
    @(posedge clock); #1;
    c_a_req = 1'b0;
    check("nc_ram_rdaddress", 32'(c_ram_rdaddress), 32'(5));
    check("nc_ram_wren", 32'(c_ram_wren), 32'(1'b0));
    @(negedge clock);
    check("nc_a_rvalid_early", 32'(c_a_rvalid), 32'(1'b0));
    @(posedge clock); #1;
    @(negedge clock);
    check("nc_a_rvalid", 32'(c_a_rvalid), 32'(1'b1));
    check("nc_b_rvalid", 32'(c_b_rvalid), 32'(1'b0));
    check("nc_rdata", 32'(c_rdata), 32'(8'h5A));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
